// File: rtl/sort_drain_pkg.sv
// Shared definitions for the serial sorting array and its drain controller.
//
// Contents:
//   CELL_EMPTY / CELL_OCCUPIED  cell_state encoding used by every sorting cell
//   drain_state_t               drain controller FSM states
//   cnt_width()                 width of a 0..n item counter
package sort_drain_pkg;

  localparam logic CELL_EMPTY    = 1'b0;
  localparam logic CELL_OCCUPIED = 1'b1;

  typedef enum logic {
    DRAIN_IDLE   = 1'b0,
    DRAIN_STREAM = 1'b1
  } drain_state_t;

  // A counter that must hold every value from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_drain.sv
// Drain controller for the serial sorting array. It reads the sorted cell
// chain out through the head cell, smallest value first, and presents the
// words as a valid/ready stream. Each captured word pulses shift_up so the
// next-smallest value moves into the head cell on the same edge.
//
// Ports:
//   clk              single clock
//   reset            synchronous, active-high
//   start_drain      one-cycle drain request (ignored while streaming)
//   num_items        occupied-cell count, sampled on an accepted start
//   head_cell_data   cell_data of cell 0
//   head_cell_state  cell_state of cell 0 (CELL_EMPTY / CELL_OCCUPIED)
//   shift_up         combinational; array shifts toward the head this edge
//   array_clear      one-cycle pulse after the final word is accepted
//   busy             high from an accepted start until done pulses
//   out_valid/out_ready/out_data/out_last   sorted output stream
//   done             one-cycle completion pulse
//   underflow        sticky: a word was captured from an EMPTY head cell
//
// state        | meaning
// -------------+-----------------------------------------------------------
// DRAIN_IDLE   | waiting for start_drain; no word held
// DRAIN_STREAM | out_data holds a valid word; remaining words still in array
module sort_drain
  import sort_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CELLS  = 16,
  parameter int CNT_W      = cnt_width(NUM_CELLS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_drain,
  input  logic [CNT_W-1:0]      num_items,
  input  logic [DATA_WIDTH-1:0] head_cell_data,
  input  logic                  head_cell_state,
  output logic                  shift_up,
  output logic                  array_clear,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic                  underflow
);

  drain_state_t     state_q, state_d;
  logic [CNT_W-1:0] remaining_q;

  logic start_ok;
  logic start_empty;
  logic handshake;
  logic take_word;
  logic take_last;
  logic capture;

  always_comb begin
    start_ok    = 1'b0;
    start_empty = 1'b0;
    handshake   = 1'b0;
    take_word   = 1'b0;
    take_last   = 1'b0;
    state_d     = state_q;

    case (state_q)
      DRAIN_IDLE: begin
        start_ok    = start_drain && (num_items != '0);
        start_empty = start_drain && (num_items == '0);
        if (start_ok) begin
          state_d = DRAIN_STREAM;
        end
      end
      DRAIN_STREAM: begin
        handshake = out_valid && out_ready;
        take_word = handshake && (remaining_q != '0);
        take_last = handshake && (remaining_q == '0);
        if (take_last) begin
          state_d = DRAIN_IDLE;
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase

    // Gated by reset so the array cannot move on an edge that also resets us.
    capture = !reset && (start_ok || take_word);
  end

  // The head is sampled on the same edge the array shifts, so each cell
  // moves exactly once per captured word.
  assign shift_up = capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DRAIN_IDLE;
      remaining_q <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      array_clear <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state_q     <= state_d;
      done        <= 1'b0;
      array_clear <= 1'b0;

      if (start_empty) begin
        done <= 1'b1;
      end

      if (start_ok) begin
        out_data    <= head_cell_data;
        remaining_q <= num_items - CNT_W'(1);
        out_last    <= (num_items == CNT_W'(1));
        out_valid   <= 1'b1;
        busy        <= 1'b1;
        // A new drain clears the old error, but its own first capture may
        // already be reading an EMPTY head.
        underflow   <= (head_cell_state == CELL_EMPTY);
      end else if (take_word) begin
        out_data    <= head_cell_data;
        remaining_q <= remaining_q - CNT_W'(1);
        out_last    <= (remaining_q == CNT_W'(1));
        if (head_cell_state == CELL_EMPTY) begin
          underflow <= 1'b1;
        end
      end else if (take_last) begin
        out_valid   <= 1'b0;
        out_last    <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        array_clear <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sort_drain.md
# sort_drain

Drain controller for the serial sorting array: it reads the sorted contents out of the cell chain, smallest value first, and presents them as a valid/ready stream. It sits between the head (lowest) sorting cell and the downstream consumer. It pulses the array's `shift_up` line once per word taken, so the next-smallest value moves into the head cell. It is the read side of the cell array; the insertion path writes the array.

## Interface
- `DATA_WIDTH`, 8, width of one sorted word.
- `NUM_CELLS`, 16, number of cells in the array; `CNT_W = $clog2(NUM_CELLS+1)`.

- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `start_drain`  in  1  one-cycle request to drain the array.
- `num_items`  in  CNT_W  occupied-cell count, sampled on an accepted `start_drain`.
- `head_cell_data`  in  DATA_WIDTH  `cell_data` of cell 0.
- `head_cell_state`  in  1  `cell_state` of cell 0 (0 EMPTY, 1 OCCUPIED).
- `shift_up`  out  1  to every cell's `shift_up`; the array shifts toward the head on this clock edge.
- `array_clear`  out  1  one-cycle pulse after the last word is accepted; returns the cells to EMPTY.
- `busy`  out  1  high from an accepted start until the cycle `done` pulses.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_data`  out  DATA_WIDTH  sorted word.
- `out_last`  out  1  marks the final word of the drain.
- `done`  out  1  one-cycle completion pulse.
- `underflow`  out  1  sticky error flag: a word was captured while the head cell was EMPTY.

## Operation
- FSM states: IDLE and STREAM. A down-counter `remaining` (CNT_W bits) and an output register hold the current word.
- **IDLE, start accepted:** `start_drain=1` with `num_items>0`:
  - capture `head_cell_data` into `out_data`;
  - drive `shift_up=1` in this cycle;
  - set `remaining <= num_items-1` and `out_last <= (num_items==1)`;
  - set `out_valid <= 1`, `busy <= 1`, clear `underflow`;
  - go to STREAM.
- **IDLE, empty start:** `start_drain=1` with `num_items==0`:
  - pulse `done` on the next cycle;
  - no `shift_up`, no stream word, no `array_clear`;
  - stay in IDLE.
- **STREAM, handshake with words left:** `out_valid & out_ready` and `remaining>0`:
  - capture `head_cell_data`, with `shift_up=1` in the same cycle;
  - decrement `remaining`; set `out_last <= (remaining==1)`;
  - `out_valid` stays high. This gives back-to-back words with no bubble.
- **STREAM, handshake on the last word:** `out_valid & out_ready` and `remaining==0`:
  - next cycle: `out_valid=0`, `out_last=0`, `busy=0`, with `done=1` and `array_clear=1` for one cycle;
  - return to IDLE.
- **STREAM, no handshake:** `out_valid & !out_ready`. `out_data` and `out_last` are held stable and `shift_up=0`.
- **Shift rule:** `shift_up` is combinational. It is high only in a cycle that captures a word, so each cell moves exactly once per captured word.
- **Underflow:** if `head_cell_state==0` in any capture cycle, set `underflow` and still output the captured value. The flag holds until the next accepted start or `reset`.
- **Start while busy:** `start_drain` in STREAM is ignored.
- **num_items above NUM_CELLS:** out of contract. Each extra capture reads an EMPTY head and sets `underflow`.

## Timing
- Reset values: `out_valid`, `out_last`, `out_data`, `busy`, `done`, `array_clear`, `underflow`, `shift_up` are all 0; FSM in IDLE; `remaining=0`.
- `reset` asserted mid-drain: IDLE on the next edge; no `done`, no `array_clear`. The array is reset separately.
- Latency, start to first word: `out_valid` is high the cycle after `start_drain`.
- Throughput: 1 word/cycle while `out_ready` is held high. An N-word drain with ready always high takes N cycles from the first `out_valid` to the final handshake; `done` follows one cycle later.
- Head data is sampled on the same edge at which the array shifts. `head_cell_data` therefore already shows the next word in the following cycle.

## Structure
- Shared sorter package holds:
  - `EMPTY`/`OCCUPIED` cell-state constants (reused from the cell);
  - the drain FSM state enum;
  - the `CNT_W` derivation function.
- No sub-module is needed: one FSM process plus a combinational `shift_up`.
- The bench uses a behavioural shift-register array model driven by `shift_up` and `array_clear`.

## Test plan
- **Basic drain:** array {3,7,9,200}, `num_items=4`, `out_ready=1`. Expect `out_data` 3,7,9,200 on 4 consecutive cycles, `out_last` only on 200, 4 `shift_up` pulses, then `done` and `array_clear` one cycle later.
- **Backpressure:** same array, `out_ready` toggling 1,0,0,1,... Expect each word held stable while ready is low, no `shift_up` in stall cycles, same order, no duplicates or drops.
- **Empty start:** `num_items=0`. Expect `done` on the next cycle and no `out_valid`, `shift_up` or `array_clear`.
- **Single item:** {42}, `num_items=1`. Expect one word 42 with `out_last=1` and exactly 1 `shift_up`.
- **Underflow and ignored start:** `num_items=3` with only 2 occupied cells. Expect `underflow=1` after the third capture. A second `start_drain` mid-stream is ignored. The next accepted start clears `underflow`.
- **Reset mid-drain:** `reset` after 2 of 5 words. Expect all outputs 0 on the next cycle, no `done`, no `array_clear`, and a clean restart afterwards.
